// File: rtl/uart_rx_v.sv
// uart_rx_v: 8N1 UART receiver with a 2-flop synchroniser and mid-bit sampling.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx_v #(
    parameter int unsigned CLK_FREQ  = 300000000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned BUS_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    output logic [BUS_WIDTH-1:0] o_data,
    output logic                 o_rx_valid,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_active
);

    localparam int unsigned ClkPerBit = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CntW      = $clog2(ClkPerBit) + 1;
    localparam int unsigned IdxW      = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;

    localparam logic [CntW-1:0] CntHalf = CntW'(ClkPerBit / 2 - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(ClkPerBit - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(BUS_WIDTH - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StWaitHigh
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StStart, StData, StStop, StWaitHigh
    } state_e;
`endif

    state_e                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [BUS_WIDTH-1:0]   shift_q, shift_d;
    logic [BUS_WIDTH-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_q, par_d;
    logic                   perr_q, perr_d;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = StStart;
                end
            end

            StStart: begin
                // A start bit that is gone by mid-bit is treated as a glitch.
                if (cnt_q == CntHalf) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? StIdle : StData;
                end
            end

            StData: begin
                if (cnt_q == CntFull) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == IdxLast) begin
                        idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == CntFull) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = StStop;
                end
            end
`endif

            StStop: begin
                // Leaving at mid-stop lets a directly following start edge be caught.
                if (cnt_q == CntFull) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = (^shift_q) ^ par_q;
`endif
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StWaitHigh;
                    end
                end
            end

            StWaitHigh: begin
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    assign o_data      = data_q;
    assign o_rx_valid  = valid_q;
    assign o_frame_err = ferr_q;
    assign o_active    = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_q;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_v.md
Name: uart_rx_v

Overview:
- UART receiver for 8N1 frames: 1 start bit, BUS_WIDTH data bits LSB first, no parity, 1 stop bit. It is the receiving end of the team's uart_tx_v transmitter.
- Synchronises the asynchronous serial line and samples each bit at mid-bit.
- Presents each received byte with a one-cycle valid strobe, and flags framing errors.
- Sits between the board RX pin and downstream command/FIFO logic.

Parameters:
- CLK_FREQ, 300000000: system clock frequency in Hz.
- BAUD_RATE, 115200: serial bit rate. CLK_PER_BIT = CLK_FREQ / BAUD_RATE, truncated (2604 at the defaults).
- BUS_WIDTH, 8: data bits per frame.

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_rx  input  1  asynchronous serial line; idles high.
- o_data  output  BUS_WIDTH  last good byte; holds its value until the next good frame.
- o_rx_valid  output  1  one-cycle pulse when o_data is updated.
- o_frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- o_parity_err  output  1  parity mismatch pulse (see Optional Feature); constant 0 when the feature is out.
- o_active  output  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- Reset (i_rst=1 at a clock edge): state=IDLE, counter=0, bit index=0, shift register=0, o_data=0, o_rx_valid=0, o_frame_err=0, o_parity_err=0, o_active=0, both synchroniser flops=1. Reset aborts any frame in progress; no strobe is emitted for it.
- Synchroniser: i_rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- Counter width: $clog2(CLK_PER_BIT)+1 bits. The counter resets to 0 on every state change.
- IDLE: when rx_s=0, go to START.
- START: count to CLK_PER_BIT/2-1 (1301 at defaults), then re-sample.
  - rx_s=0: go to DATA.
  - rx_s=1: glitch; return to IDLE with no strobe.
- DATA: at count CLK_PER_BIT-1, shift rx_s into bit[index], LSB first. After bit BUS_WIDTH-1, go to STOP (or PARITY when the feature is compiled in).
- STOP: at count CLK_PER_BIT-1, sample rx_s.
  - rx_s=1: load o_data from the shift register, pulse o_rx_valid for 1 cycle, go to IDLE.
  - rx_s=0: pulse o_frame_err for 1 cycle, leave o_data unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. A held-low break line therefore produces exactly one o_frame_err and no further frames.
- Timing: return to IDLE happens at mid-stop-bit, so a new start edge arriving directly after the stop bit is accepted. Back-to-back frames must be received with no loss.
- Latency: o_rx_valid rises (BUS_WIDTH+1)*CLK_PER_BIT + CLK_PER_BIT/2 + 4 cycles ±2 after the i_rx falling edge of the start bit.
- o_rx_valid and o_frame_err are never high in the same cycle.
- Changes on i_rx between sample points are ignored; there is no majority vote.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP. It samples one bit at count CLK_PER_BIT-1.
  - Parity is even: the XOR of the data bits and the parity bit must be 0.
  - On a good stop bit, o_rx_valid pulses and o_data updates regardless of parity. o_parity_err pulses in the same cycle when parity mismatches.
  - Latency grows by CLK_PER_BIT.
- Undefined: 8N1 only. o_parity_err is tied to 0 and there is no PARITY state.

Test Plan:
- Send 0x55 at 2604 cycles/bit after reset -> a single o_rx_valid pulse with o_data=0x55 at the specified latency ±2; o_frame_err stays 0; o_active high for the whole frame.
- Send 0xA5 then 0x3C back-to-back with no idle gap -> two o_rx_valid pulses, o_data=0xA5 then 0x3C; the second frame must not be lost.
- Drive i_rx low for 500 cycles, then high -> no strobe; o_active falls back to 0 within 1310 cycles; o_data unchanged.
- Send 0xF0 with the stop bit driven low, then hold low 5 bit times, then high, then send 0x12 -> exactly one o_frame_err pulse, no o_rx_valid for 0xF0, then o_rx_valid with o_data=0x12.
- Assert i_rst for 1 cycle during data bit 4 of 0x81, then send 0x7E -> no strobe for 0x81; outputs read 0 after reset; o_data=0x7E afterward.
- With UART_RX_PARITY_EN: send 0x03 with parity bit 0 -> o_rx_valid, o_parity_err=0. Send 0x03 with parity bit 1 -> o_rx_valid and o_parity_err pulse together, o_data=0x03.
